// File: rtl/sdram_cmd_arbiter.sv
// Two-port command arbiter in front of SDRAMController: round-robin with bounded burst hold,
// plus a tag FIFO that steers each returning read word back to the port that issued it.
module sdram_cmd_arbiter #(
    parameter int unsigned AddrWidth = 23,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned MaxBurst  = 8,
    parameter int unsigned ReadDepth = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_a_trigger,
    output logic                 o_a_ready,
    input  logic                 i_a_write,
    input  logic [AddrWidth-1:0] i_a_addr,
    input  logic [DataWidth-1:0] i_a_write_data,
    output logic [DataWidth-1:0] o_a_read_data,
    output logic                 o_a_read_data_valid,
    input  logic                 i_b_trigger,
    output logic                 o_b_ready,
    input  logic                 i_b_write,
    input  logic [AddrWidth-1:0] i_b_addr,
    input  logic [DataWidth-1:0] i_b_write_data,
    output logic [DataWidth-1:0] o_b_read_data,
    output logic                 o_b_read_data_valid,
    input  logic                 i_cmd_ready,
    output logic                 o_cmd_trigger,
    output logic                 o_cmd_write,
    output logic [AddrWidth-1:0] o_cmd_addr,
    output logic [DataWidth-1:0] o_cmd_write_data,
    input  logic [DataWidth-1:0] i_cmd_read_data,
    input  logic                 i_cmd_read_data_valid,
    output logic                 o_orphan_err
);

    localparam int unsigned PtrW   = $clog2(ReadDepth);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned BurstW = $clog2(MaxBurst + 1);
    localparam logic [CntW-1:0]   DepthC    = CntW'(ReadDepth);
    localparam logic [BurstW-1:0] MaxBurstC = BurstW'(MaxBurst);

    typedef enum logic {PortA = 1'b0, PortB = 1'b1} port_e;

    port_e             r_last;
    logic [BurstW-1:0] r_burst_cnt;
    logic [CntW-1:0]   r_count;
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    port_e             r_tags [ReadDepth];
    logic              r_orphan_err;

    port_e w_sel;
    port_e w_head;
    logic  w_sel_trigger;
    logic  w_sel_write;
    logic  w_full;
    logic  w_empty;
    logic  w_blk;
    logic  w_sel_ready;
    logic  w_accept;
    logic  w_push;
    logic  w_pop;

    always_comb begin
        w_sel = PortA;
        case ({i_a_trigger, i_b_trigger})
            2'b10:   w_sel = PortA;
            2'b01:   w_sel = PortB;
            2'b11: begin
                // A zero count means nobody holds the grant yet (post-reset), so the port
                // that did not go last wins; otherwise hold until the burst cap is reached.
                if (r_burst_cnt == '0 || r_burst_cnt >= MaxBurstC) begin
                    w_sel = (r_last == PortA) ? PortB : PortA;
                end else begin
                    w_sel = r_last;
                end
            end
            default: w_sel = PortA;
        endcase
    end

    always_comb begin
        w_sel_trigger    = i_a_trigger;
        w_sel_write      = i_a_write;
        o_cmd_addr       = i_a_addr;
        o_cmd_write_data = i_a_write_data;
        if (w_sel == PortB) begin
            w_sel_trigger    = i_b_trigger;
            w_sel_write      = i_b_write;
            o_cmd_addr       = i_b_addr;
            o_cmd_write_data = i_b_write_data;
        end
    end

    assign o_cmd_write = w_sel_write;
    assign w_full      = (r_count == DepthC);
    assign w_empty     = (r_count == '0);
    // A blocked read keeps the grant; the other port waits until a tag frees.
    assign w_blk       = !w_sel_write && w_full;

    assign o_cmd_trigger = i_rst_n && w_sel_trigger && !w_blk;
    assign w_sel_ready   = i_rst_n && i_cmd_ready && !w_blk;
    assign o_a_ready     = w_sel_ready && (w_sel == PortA);
    assign o_b_ready     = w_sel_ready && (w_sel == PortB);

    assign w_accept = o_cmd_trigger && i_cmd_ready;
    assign w_push   = w_accept && !w_sel_write;
    assign w_pop    = i_cmd_read_data_valid && !w_empty;
    assign w_head   = r_tags[r_rd_ptr];

    assign o_a_read_data       = i_cmd_read_data;
    assign o_b_read_data       = i_cmd_read_data;
    assign o_a_read_data_valid = w_pop && (w_head == PortA);
    assign o_b_read_data_valid = w_pop && (w_head == PortB);
    assign o_orphan_err        = r_orphan_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last       <= PortB;
            r_burst_cnt  <= '0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_orphan_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_sel == r_last) begin
                    r_burst_cnt <= (r_burst_cnt >= MaxBurstC) ? MaxBurstC
                                                              : r_burst_cnt + BurstW'(1);
                end else begin
                    r_burst_cnt <= BurstW'(1);
                end
                r_last <= w_sel;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_count <= r_count + {{PtrW{1'b0}}, w_push} - {{PtrW{1'b0}}, w_pop};
            if (i_cmd_read_data_valid && w_empty) begin
                r_orphan_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_tags[r_wr_ptr] <= w_sel;
        end
    end

endmodule
